// File: rtl/updown_button_ctrl_pkg.sv
// Shared definitions for the up/down button conditioning block: FSM encoding,
// direction constants and default parameter values.
package updown_button_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HOLD = 2'd1,
    REPEAT    = 2'd2
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_HOLD_CYCLES     = 8;
  localparam int DEF_REPEAT_CYCLES   = 3;
  localparam bit DEF_REPEAT_EN       = 1'b1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/updown_button_ctrl_debounce.sv
// One button channel: two-flop synchronizer followed by a counter that accepts a
// new level only after it has persisted for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce
  import updown_button_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          db_q;
  logic          db_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Debounce next-state: any cycle where sync matches db restarts the count
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (sync2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      db_d  = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Synchronizer and debounce state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = db_q;

endmodule

// File: rtl/updown_button_ctrl.sv
// Button conditioning for the up/down counter: debounces the two raw buttons and
// turns presses into exclusive single-cycle increment/decrement pulses with auto-repeat.
module updown_button_ctrl
  import updown_button_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter bit REPEAT_EN       = DEF_REPEAT_EN
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  output logic increment,
  output logic decrement,
  output logic busy
);

  localparam int TW = $clog2(max2(HOLD_CYCLES, REPEAT_CYCLES));
  localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYCLES - 1);

  logic          db_up_s;
  logic          db_down_s;
  logic          abort_s;
  logic          fire_s;
  state_e        state_q;
  state_e        state_d;
  logic          dir_q;
  logic          dir_d;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;
  logic          inc_q;
  logic          inc_d;
  logic          dec_q;
  logic          dec_d;
  logic          busy_q;
  logic          busy_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_up),
    .level (db_up_s)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_down),
    .level (db_down_s)
  );

  // A press ends when its own button releases or the opposite one joins in
  assign abort_s = (dir_q == DIR_UP) ? (!db_up_s || db_down_s)
                                     : (!db_down_s || db_up_s);

  // Next-state logic: FSM transitions, direction capture and hold/repeat timer
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    timer_d = timer_q;
    fire_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (db_up_s && !db_down_s) begin
          fire_s  = 1'b1;
          dir_d   = DIR_UP;
          timer_d = '0;
          state_d = WAIT_HOLD;
        end else if (db_down_s && !db_up_s) begin
          fire_s  = 1'b1;
          dir_d   = DIR_DOWN;
          timer_d = '0;
          state_d = WAIT_HOLD;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_HOLD: begin
        if (abort_s) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (!REPEAT_EN) begin
          state_d = WAIT_HOLD;
        end else if (timer_q == HOLD_LAST) begin
          fire_s  = 1'b1;
          timer_d = '0;
          state_d = REPEAT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      REPEAT: begin
        if (abort_s) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == REPEAT_LAST) begin
          fire_s  = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Output decode: steer a fire event to exactly one pulse by direction
  always_comb begin
    inc_d  = 1'b0;
    dec_d  = 1'b0;
    if (fire_s) begin
      if (dir_d == DIR_UP) begin
        inc_d = 1'b1;
      end else begin
        dec_d = 1'b1;
      end
    end else begin
      inc_d = 1'b0;
      dec_d = 1'b0;
    end
    busy_d = (state_d != IDLE);
  end

  // State and registered output flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q   <= DIR_DOWN;
      timer_q <= '0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      timer_q <= timer_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      busy_q  <= busy_d;
    end
  end

  assign increment = inc_q;
  assign decrement = dec_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_updown_button_ctrl.sv
// Self-checking bench for updown_button_ctrl: directed scenarios with timing checks
// plus randomized button activity compared against a press-age reference model.
module tb_updown_button_ctrl;

  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int REP  = 3;
  localparam int LAT  = DEB + 3;

  logic clk = 1'b0;
  logic reset;
  logic btn_up;
  logic btn_down;
  logic increment, decrement, busy;
  logic nr_inc, nr_dec, nr_busy;

  int checks = 0;
  int errors = 0;
  int t = 0;

  // Reference model state: raw/sync history, debounced levels, press owner and age
  bit m_s1 [2];
  bit m_s2 [2];
  bit m_db [2];
  int m_run [2];
  int owner;
  int age;
  bit exp_inc, exp_dec, exp_busy;

  // Downstream counter driven by the pulses
  logic [3:0] ctr;
  logic       both_seen;

  always #5 clk = ~clk;

  updown_button_ctrl #(
    .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .REPEAT_EN(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
    .increment(increment), .decrement(decrement), .busy(busy)
  );

  updown_button_ctrl #(
    .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .REPEAT_EN(1'b0)
  ) dut_nr (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
    .increment(nr_inc), .decrement(nr_dec), .busy(nr_busy)
  );

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ctr       <= 4'd0;
      both_seen <= 1'b0;
    end else if (increment && decrement) begin
      both_seen <= 1'b1;
    end else if (increment) begin
      ctr <= ctr + 4'd1;
    end else if (decrement) begin
      ctr <= ctr - 4'd1;
    end
  end

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_db[i] = 1'b0; m_run[i] = 0;
    end
    owner = -1; age = 0;
    exp_inc = 1'b0; exp_dec = 1'b0; exp_busy = 1'b0;
  endtask

  // One clock of the model: a press fires on acceptance, then at age HOLD, HOLD+REP, ...
  task automatic model_step(input bit raw_up, input bit raw_down, input bit rst);
    bit fire;
    if (rst) begin
      model_clear();
    end else begin
      fire = 1'b0;
      if (owner < 0) begin
        if (m_db[0] != m_db[1]) begin
          owner = m_db[0] ? 0 : 1;
          age   = 0;
          fire  = 1'b1;
        end
      end else if (!m_db[owner] || m_db[1-owner]) begin
        owner = -1;
      end else begin
        age++;
        if (age >= HOLD && ((age - HOLD) % REP) == 0) fire = 1'b1;
      end
      exp_inc  = fire && (owner == 0);
      exp_dec  = fire && (owner == 1);
      exp_busy = (owner >= 0);
      for (int i = 0; i < 2; i++) begin
        if (m_s2[i] == m_db[i]) begin
          m_run[i] = 0;
        end else begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_db[i]  = m_s2[i];
            m_run[i] = 0;
          end
        end
      end
      m_s2 = m_s1;
      m_s1[0] = raw_up;
      m_s1[1] = raw_down;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(btn_up, btn_down, reset);
    t++;
    #1;
  endtask

  task automatic drain(input int n);
    btn_up = 1'b0; btn_down = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    int first_inc;
    reset = 1'b1; btn_up = 1'b0; btn_down = 1'b0;
    repeat (3) tick();
    checks++;
    if ({increment, decrement, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_state: got %b expected 000", {increment, decrement, busy});
    end
    reset = 1'b0;
    btn_up = 1'b1;
    repeat (LAT + 1) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL reset_pre_busy: got %b expected 1", busy);
    end
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    checks++;
    if ({increment, decrement, busy, nr_busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_async: got %b expected 0000", {increment, decrement, busy, nr_busy});
    end
    repeat (2) tick();
    reset = 1'b0;
    t = 0; first_inc = -1;
    repeat (12) begin
      tick();
      if (increment && first_inc < 0) first_inc = t;
    end
    checks++;
    if (first_inc != LAT) begin
      errors++; $display("FAIL reset_repress: first increment at %0d expected %0d", first_inc, LAT);
    end
    drain(16);
  endtask

  task automatic test_clean_press();
    int inc_n, dec_n, first_inc;
    bit busy7;
    inc_n = 0; dec_n = 0; first_inc = -1; busy7 = 1'b0;
    t = 0; btn_up = 1'b1;
    repeat (24) begin
      if (t == 6) btn_up = 1'b0;
      tick();
      if (increment) begin inc_n++; if (first_inc < 0) first_inc = t; end
      if (decrement) dec_n++;
      if (t == LAT) busy7 = busy;
    end
    checks++;
    if (inc_n != 1) begin errors++; $display("FAIL clean_inc_count: got %0d expected 1", inc_n); end
    checks++;
    if (first_inc != LAT) begin errors++; $display("FAIL clean_latency: got %0d expected %0d", first_inc, LAT); end
    checks++;
    if (dec_n != 0) begin errors++; $display("FAIL clean_dec_count: got %0d expected 0", dec_n); end
    checks++;
    if (busy7 !== 1'b1) begin errors++; $display("FAIL clean_busy: got %b expected 1", busy7); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL clean_idle: got %b expected 0", busy); end
  endtask

  task automatic test_bounce();
    int bounce_n, inc_n, first_inc;
    bounce_n = 0; inc_n = 0; first_inc = -1;
    for (int k = 0; k < 12; k++) begin
      btn_up = ((k / 2) % 2) == 0;
      tick();
      if (increment || decrement) bounce_n++;
    end
    btn_up = 1'b1; t = 0;
    repeat (10) begin
      tick();
      if (increment || decrement) bounce_n += (t < LAT) ? 1 : 0;
      if (increment) begin inc_n++; if (first_inc < 0) first_inc = t; end
    end
    checks++;
    if (bounce_n != 0) begin errors++; $display("FAIL bounce_reject: got %0d pulses expected 0", bounce_n); end
    checks++;
    if (inc_n != 1 || first_inc != LAT) begin
      errors++; $display("FAIL bounce_settle: got %0d pulses first %0d expected 1 at %0d", inc_n, first_inc, LAT);
    end
    drain(16);
  endtask

  task automatic test_auto_repeat();
    int dec_n, inc_n, nr_n, nr_first;
    bit good, nr_busy30;
    dec_n = 0; inc_n = 0; nr_n = 0; nr_first = -1; nr_busy30 = 1'b0;
    t = 0; btn_down = 1'b1;
    repeat (48) begin
      if (t == 30) btn_down = 1'b0;
      tick();
      if (decrement) begin
        dec_n++;
        good = (t == LAT) || (t >= LAT + HOLD && ((t - LAT - HOLD) % REP) == 0 && t <= 30 + LAT);
        checks++;
        if (!good) begin errors++; $display("FAIL repeat_time: decrement at %0d not expected", t); end
      end
      if (increment || nr_inc) inc_n++;
      if (nr_dec) begin nr_n++; if (nr_first < 0) nr_first = t; end
      if (t == 30) nr_busy30 = nr_busy;
    end
    checks++;
    if (dec_n != 9) begin errors++; $display("FAIL repeat_count: got %0d expected 9", dec_n); end
    checks++;
    if (inc_n != 0) begin errors++; $display("FAIL repeat_no_inc: got %0d expected 0", inc_n); end
    checks++;
    if (nr_n != 1 || nr_first != LAT) begin
      errors++; $display("FAIL norepeat_single: got %0d pulses first %0d expected 1 at %0d", nr_n, nr_first, LAT);
    end
    checks++;
    if (nr_busy30 !== 1'b1) begin errors++; $display("FAIL norepeat_busy: got %b expected 1", nr_busy30); end
    drain(4);
  endtask

  task automatic test_both_buttons();
    int held_n, dec_n, inc_n, first_dec;
    held_n = 0; dec_n = 0; inc_n = 0; first_dec = -1;
    btn_up = 1'b1; btn_down = 1'b1;
    repeat (20) begin
      tick();
      if (increment || decrement) held_n++;
    end
    checks++;
    if (held_n != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL both_held: got %0d pulses busy %b expected 0 pulses busy 0", held_n, busy);
    end
    btn_up = 1'b0; t = 0;
    repeat (12) begin
      tick();
      if (decrement) begin dec_n++; if (first_dec < 0) first_dec = t; end
      if (increment) inc_n++;
    end
    checks++;
    if (dec_n != 1 || first_dec != LAT || inc_n != 0) begin
      errors++; $display("FAIL both_release: got dec %0d at %0d inc %0d expected dec 1 at %0d inc 0",
                         dec_n, first_dec, inc_n, LAT);
    end
    drain(16);
  endtask

  task automatic test_integration();
    reset = 1'b1;
    model_clear();
    tick();
    reset = 1'b0;
    for (int p = 0; p < 4; p++) begin
      if (p < 3) btn_up = 1'b1; else btn_down = 1'b1;
      repeat (6) tick();
      drain(12);
      if (p == 2) begin
        checks++;
        if (ctr !== 4'd3) begin errors++; $display("FAIL integ_up3: got %0d expected 3", ctr); end
      end
    end
    checks++;
    if (ctr !== 4'd2) begin errors++; $display("FAIL integ_count: got %0d expected 2", ctr); end
    checks++;
    if (both_seen !== 1'b0) begin errors++; $display("FAIL integ_exclusive: got %b expected 0", both_seen); end
  endtask

  task automatic test_random();
    int dur;
    for (int k = 0; k < 70; k++) begin
      btn_up   = 1'($urandom_range(0, 1));
      btn_down = 1'($urandom_range(0, 1));
      dur      = $urandom_range(1, 14);
      repeat (dur) begin
        tick();
        checks++;
        if ({increment, decrement, busy} !== {exp_inc, exp_dec, exp_busy}) begin
          errors++;
          $display("FAIL random_model t=%0d: got inc/dec/busy %b expected %b",
                   t, {increment, decrement, busy}, {exp_inc, exp_dec, exp_busy});
        end
      end
    end
    drain(16);
  endtask

  initial begin
    reset = 1'b1; btn_up = 1'b0; btn_down = 1'b0;
    model_clear();
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_both_buttons();
    test_integration();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
